// File: rtl/sbox_arbiter_ctrl_if.sv
// rtl/sbox_arbiter_ctrl_if.sv - requester-side bus of the shared S-box arbiter
interface sbox_arbiter_ctrl_if;
  logic         st_req;
  logic         st_inv;
  logic [127:0] st_in;
  logic         st_ack;
  logic [127:0] st_out;
  logic         st_vld;
  logic         key_req;
  logic [31:0]  key_in;
  logic         key_ack;
  logic [31:0]  key_out;
  logic         key_vld;
  logic         busy;

  modport master (
    output st_req, st_inv, st_in, key_req, key_in,
    input  st_ack, st_out, st_vld, key_ack, key_out, key_vld, busy
  );

  modport slave (
    input  st_req, st_inv, st_in, key_req, key_in,
    output st_ack, st_out, st_vld, key_ack, key_out, key_vld, busy
  );
endinterface

// File: rtl/sbox_arbiter_ctrl.sv
// rtl/sbox_arbiter_ctrl.sv - one 32-bit SubBytes word path shared by state and key requesters
// SBOX_ROUND_ROBIN_EN: round-robin grant on simultaneous requests (default: key wins)
module sbox_arbiter_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  sbox_arbiter_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] KEY_RUN = 2'd2;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] a, input logic inv);
    logic [7:0] s;
    logic [7:0] t;
    if (inv) begin
      t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      s = gf_inv(t);
    end else begin
      t = gf_inv(a);
      s = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
    end
    return s;
  endfunction

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [127:0] st_q;
  logic         inv_q;
  logic [31:0]  key_q;
  logic         idle;
  logic         key_win;
  logic         inv_en;
  logic [31:0]  lane_in;
  logic [31:0]  lane_out;
  logic [31:0]  st_word;

  assign idle = (state == IDLE);

`ifdef SBOX_ROUND_ROBIN_EN
  logic st_pri;

  assign key_win = bus.key_req & ~(bus.st_req & st_pri);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_pri <= 1'b0;
    end else if (bus.key_ack) begin
      st_pri <= 1'b1;
    end else if (bus.st_ack) begin
      st_pri <= 1'b0;
    end
  end
`else
  assign key_win = bus.key_req;
`endif

  // acks are gated by rst_n so nothing is granted while reset is held
  assign bus.key_ack = rst_n & idle & key_win;
  assign bus.st_ack  = rst_n & idle & bus.st_req & ~key_win;
  assign bus.busy    = ~idle;

  always_comb begin
    st_word = st_q[127:96];
    case (cnt)
      2'd0: st_word = st_q[127:96];
      2'd1: st_word = st_q[95:64];
      2'd2: st_word = st_q[63:32];
      2'd3: st_word = st_q[31:0];
      default: st_word = st_q[127:96];
    endcase
  end

  assign lane_in = (state == ST_RUN) ? st_word : key_q;
  assign inv_en  = (state == ST_RUN) & inv_q;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane_out[8*k+7:8*k] = sbox_byte(lane_in[8*k+7:8*k], inv_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      st_q        <= 128'd0;
      inv_q       <= 1'b0;
      key_q       <= 32'd0;
      bus.st_out  <= 128'd0;
      bus.key_out <= 32'd0;
      bus.st_vld  <= 1'b0;
      bus.key_vld <= 1'b0;
    end else begin
      bus.st_vld  <= 1'b0;
      bus.key_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.st_ack) begin
            st_q  <= bus.st_in;
            inv_q <= bus.st_inv;
            cnt   <= 2'd0;
            state <= ST_RUN;
          end else if (bus.key_ack) begin
            key_q <= bus.key_in;
            state <= KEY_RUN;
          end
        end
        ST_RUN: begin
          case (cnt)
            2'd0: bus.st_out[127:96] <= lane_out;
            2'd1: bus.st_out[95:64]  <= lane_out;
            2'd2: bus.st_out[63:32]  <= lane_out;
            default: bus.st_out[31:0] <= lane_out;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state      <= IDLE;
            bus.st_vld <= 1'b1;
          end
        end
        KEY_RUN: begin
          bus.key_out <= lane_out;
          bus.key_vld <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_arbiter_ctrl.sv
// tb/tb_sbox_arbiter_ctrl.sv - directed self-checking bench for sbox_arbiter_ctrl
module tb_sbox_arbiter_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sbox_arbiter_ctrl_if bus ();

  sbox_arbiter_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_st_ack(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.st_ack) ok = 1'b1;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_key_ack(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.key_ack) ok = 1'b1;
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic run_state(input string tag, input logic inv, input logic [127:0] din,
                           input logic [127:0] exp);
    @(posedge clk); #1;
    bus.st_req = 1'b1;
    bus.st_inv = inv;
    bus.st_in  = din;
    wait_st_ack({tag, "_ack"});
    @(posedge clk); #1;
    bus.st_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, bus.busy, 1'b1);
      chk({tag, "_novld"}, bus.st_vld, 1'b0);
    end
    @(negedge clk);
    chk({tag, "_vld"}, bus.st_vld, 1'b1);
    chk({tag, "_out"}, bus.st_out, exp);
    chk({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic run_key(input string tag, input logic [31:0] din, input logic [31:0] exp);
    @(posedge clk); #1;
    bus.key_req = 1'b1;
    bus.key_in  = din;
    wait_key_ack({tag, "_ack"});
    @(posedge clk); #1;
    bus.key_req = 1'b0;
    @(negedge clk);
    chk({tag, "_novld"}, bus.key_vld, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b1);
    @(negedge clk);
    chk({tag, "_vld"}, bus.key_vld, 1'b1);
    chk({tag, "_out"}, bus.key_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte glog [4];
    int  ng;
    int  nst;
    int  nboth;
    int  nvld;
    bit  done;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.st_req  = 1'b1;
    bus.st_inv  = 1'b0;
    bus.st_in   = '0;
    bus.key_req = 1'b1;
    bus.key_in  = '0;

    // reset state, with both requests held to confirm acks are masked
    @(negedge clk);
    chk("rst_st_ack", bus.st_ack, 1'b0);
    chk("rst_key_ack", bus.key_ack, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_st_out", bus.st_out, 128'd0);
    chk("rst_key_out", bus.key_out, 32'd0);
    chk("rst_vld", {bus.st_vld, bus.key_vld}, 2'b00);
    bus.st_req  = 1'b0;
    bus.key_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_state("fwd_zero", 1'b0, 128'd0, {16{8'h63}});
    run_key("key_sub", 32'hCF4F3C09, 32'h8A84EB01);
    run_state("inv_63", 1'b1, {16{8'h63}}, 128'd0);
    chk("key_hold1", bus.key_out, 32'h8A84EB01);
    run_state("fwd_53", 1'b0, {32'h53000000, 96'd0}, {32'hED636363, {12{8'h63}}});
    chk("key_hold2", bus.key_out, 32'h8A84EB01);

    // key request arriving during word 1 must wait for the state job
    @(posedge clk); #1;
    bus.st_req = 1'b1;
    bus.st_inv = 1'b1;
    bus.st_in  = {32'h16ED6300, {12{8'h63}}};
    wait_st_ack("pre_ack");
    @(posedge clk); #1;
    bus.st_req = 1'b0;
    @(posedge clk); #1;
    bus.key_req = 1'b1;
    bus.key_in  = 32'h00FF0153;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("pre_key_wait", bus.key_ack, 1'b0);
    end
    @(negedge clk);
    chk("pre_st_vld", bus.st_vld, 1'b1);
    chk("pre_key_ack", bus.key_ack, 1'b1);
    chk("pre_st_out", bus.st_out, {32'hFF530052, 96'd0});
    @(posedge clk); #1;
    bus.key_req = 1'b0;
    @(negedge clk);
    chk("pre_key_novld", bus.key_vld, 1'b0);
    @(negedge clk);
    chk("pre_key_vld", bus.key_vld, 1'b1);
    chk("pre_key_out", bus.key_out, 32'h63167CED);

    // both requests held continuously
    ng    = 0;
    nst   = 0;
    nboth = 0;
    @(posedge clk); #1;
    bus.st_req  = 1'b1;
    bus.st_inv  = 1'b0;
    bus.st_in   = '0;
    bus.key_req = 1'b1;
    bus.key_in  = 32'h01010101;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.st_ack && bus.key_ack) nboth++;
      if (bus.st_ack) nst++;
      if ((bus.st_ack || bus.key_ack) && ng < 4) begin
        glog[ng] = bus.key_ack ? "K" : "S";
        ng++;
      end
    end
    @(posedge clk); #1;
    bus.st_req  = 1'b0;
    bus.key_req = 1'b0;
    chk("arb_both", nboth, 0);
    chk("arb_count", ng, 4);
`ifdef SBOX_ROUND_ROBIN_EN
    chk("arb_g0", glog[0], "K");
    chk("arb_g1", glog[1], "S");
    chk("arb_g2", glog[2], "K");
    chk("arb_g3", glog[3], "S");
`else
    chk("arb_g0", glog[0], "K");
    chk("arb_g3", glog[3], "K");
    chk("arb_no_st", nst, 0);
`endif
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    chk("arb_drain", done, 1'b1);
    @(negedge clk);

    // reset during word 2 aborts the job
    @(posedge clk); #1;
    bus.st_req  = 1'b1;
    bus.st_inv  = 1'b0;
    bus.st_in   = {16{8'h01}};
    bus.key_req = 1'b0;
    wait_st_ack("abort_ack");
    @(posedge clk); #1;
    bus.st_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_st_out", bus.st_out, 128'd0);
    chk("abort_key_out", bus.key_out, 32'd0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_vld", {bus.st_vld, bus.key_vld}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvld = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.st_vld || bus.key_vld) nvld++;
    end
    chk("abort_no_vld", nvld, 0);
    run_state("post_rst", 1'b0, {16{8'h01}}, {16{8'h7C}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sbox_arbiter_ctrl.md
SBOX_ARBITER_CTRL -- requirements
Module: sbox_arbiter_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
REQ-002 The state-requester ports SHALL be:
  st_req  input  1  state substitution request; held high until st_ack
  st_inv  input  1  1 = inverse S-box, 0 = forward; sampled with st_req at grant
  st_in  input  128  state; word 0 = st_in[127:96], word 3 = st_in[31:0]
  st_ack  output  1  grant pulse; st_in and st_inv captured this cycle
  st_out  output  128  substituted state, word order as st_in
  st_vld  output  1  one-cycle pulse; st_out valid
REQ-003 The key-requester ports SHALL be:
  key_req  input  1  SubWord request; held high until key_ack
  key_in  input  32  word for SubWord; always forward S-box
  key_ack  output  1  grant pulse; key_in captured this cycle
  key_out  output  32  SubWord(key_in)
  key_vld  output  1  one-cycle pulse; key_out valid
  busy  output  1  high whenever FSM is not IDLE

Function
REQ-004 The block SHALL contain exactly four SubBytes lanes forming one 32-bit word datapath, shared by both requesters; lane k maps word bits [8k+7:8k].
REQ-005 FSM states SHALL be IDLE, ST_RUN and KEY_RUN.
REQ-006 st_ack and key_ack SHALL be combinational, asserted only in IDLE, at most one per cycle; the granted input SHALL be registered on that edge.
REQ-007 IDLE->ST_RUN on st_ack; IDLE->KEY_RUN on key_ack; IDLE otherwise.
REQ-008 ST_RUN SHALL run a 2-bit word counter 0..3, substituting one word per cycle with the captured st_inv, writing the result into the corresponding st_out word; after word 3 it SHALL return to IDLE.
REQ-009 State latency: if st_ack is high in cycle t, words are processed in cycles t+1..t+4 and st_vld SHALL be high in cycle t+5 only.
REQ-010 KEY_RUN SHALL last one cycle, with inv_en=0: key_ack in cycle t gives key_vld high in cycle t+2 only, then IDLE.
REQ-011 A new grant SHALL be possible in the same cycle that st_vld or key_vld is high (back-to-back jobs, no bubble).
REQ-012 A job in progress SHALL NOT be preempted; a request arriving while busy SHALL wait with no ack until IDLE.
REQ-013 st_out and key_out SHALL hold their last values until overwritten by the next job of the same requester; st_out SHALL be updated word by word during ST_RUN.
REQ-014 Simultaneous st_req and key_req in IDLE SHALL be resolved per REQ-018/REQ-019.
REQ-015 A requester deasserting req before ack SHALL be legal; no ack and no state change result.

Reset
REQ-016 When rst_n is low: FSM = IDLE, word counter = 0, st_out = 0, key_out = 0, st_vld = key_vld = 0, busy = 0, captured registers = 0, round-robin pointer = key-favoured; acks SHALL be 0.
REQ-017 Reset asserted mid-job SHALL abort the job immediately; no vld pulse SHALL follow reset release unless a new job is granted.

Configuration
REQ-018 With macro SBOX_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted most recently; the pointer updates on every ack and starts key-favoured after reset.
REQ-019 Without SBOX_ROUND_ROBIN_EN, key_req SHALL always win simultaneous requests (fixed priority), and no pointer register SHALL exist.

Verification
REQ-020 st_req, st_inv=0, st_in=all 0x00 -> st_ack in cycle t; st_vld in t+5 only; st_out = all 0x63; busy high t+1..t+4.
REQ-021 st_inv=1, st_in=all 0x63 -> st_out = all 0x00; then st_inv=0, st_in word 0 = 0x53000000 -> st_out[127:96] = 0xED636363.
REQ-022 key_req, key_in=0xCF4F3C09 -> key_vld at t+2, key_out=0x8A84EB01; key_out held through a following state job.
REQ-023 key_req rising during ST_RUN word 1 -> no key_ack until IDLE; key_ack in the st_vld cycle; key_vld 2 cycles later.
REQ-024 Both reqs held high continuously: with SBOX_ROUND_ROBIN_EN, grants alternate key, state, key, ...; without it, only key is granted.
REQ-025 rst_n pulsed low during ST_RUN word 2 -> all outputs 0 at once; no st_vld after release; next st_req completes normally.
